// File: rtl/dma_controller.sv
// dma_controller: single-channel byte-copy DMA engine with a 6-byte io register window and a bus master port.
// Define DMA_FILL_EN to build the constant-byte fill mode (CTRL bit2 / STATUS bit3).
module dma_controller #(
    parameter logic [7:0] DMA_ADDRESS = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic [7:0]  address,
    input  logic        w_en,
    input  logic        r_en,
    output logic [7:0]  dout,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] m_address,
    output logic [7:0]  m_dout,
    output logic        m_w_en,
    output logic        m_r_en,
    input  logic [7:0]  m_din,
    output logic        done_flag
);

    typedef enum logic [2:0] {IDLE, REQ, READ, CAPTURE, WRITE} state_t;

    localparam logic [7:0] OFF_SRC_L = 8'd0;
    localparam logic [7:0] OFF_SRC_H = 8'd1;
    localparam logic [7:0] OFF_DST_L = 8'd2;
    localparam logic [7:0] OFF_DST_H = 8'd3;
    localparam logic [7:0] OFF_LEN   = 8'd4;
    localparam logic [7:0] OFF_CTRL  = 8'd5;

    state_t      state_reg;
    logic [15:0] src_reg;
    logic [15:0] dst_reg;
    logic [7:0]  len_reg;
    logic [7:0]  data_reg;
    logic        done_reg;
    logic        aborted_reg;
    logic        abort_pending_reg;
    logic        fill_mode;

    logic [7:0]  offset;
    logic        hit;
    logic        busy;
    logic        ctrl_wr;
    logic        start_wr;
    logic        abort_wr;
    logic        status_rd;

    // Unsigned wrap makes addresses below the base land outside the window.
    assign offset    = address - DMA_ADDRESS;
    assign hit       = (offset < 8'd6);
    assign busy      = (state_reg != IDLE);
    assign ctrl_wr   = w_en && hit && (offset == OFF_CTRL);
    assign start_wr  = ctrl_wr && din[0];
    assign abort_wr  = ctrl_wr && din[1];
    assign status_rd = r_en && hit && (offset == OFF_CTRL);

`ifdef DMA_FILL_EN
    logic fill_reg;
    assign fill_mode = fill_reg;
`else
    assign fill_mode = 1'b0;
`endif

    assign m_dout = (state_reg == WRITE) ? data_reg : 8'h00;

    always_comb begin
        dout = 8'h00;
        if (r_en && hit) begin
            case (offset)
                OFF_SRC_L: dout = src_reg[7:0];
                OFF_SRC_H: dout = src_reg[15:8];
                OFF_DST_L: dout = dst_reg[7:0];
                OFF_DST_H: dout = dst_reg[15:8];
                OFF_LEN:   dout = len_reg;
                OFF_CTRL:  dout = {4'b0000, fill_mode, aborted_reg, done_reg, busy};
                default:   dout = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            src_reg           <= 16'h0000;
            dst_reg           <= 16'h0000;
            len_reg           <= 8'h00;
            data_reg          <= 8'h00;
            done_reg          <= 1'b0;
            aborted_reg       <= 1'b0;
            abort_pending_reg <= 1'b0;
            bus_req           <= 1'b0;
            m_address         <= 16'h0000;
            m_r_en            <= 1'b0;
            m_w_en            <= 1'b0;
            done_flag         <= 1'b0;
`ifdef DMA_FILL_EN
            fill_reg          <= 1'b0;
`endif
        end else begin
            // Bus strobes are single-cycle; each transition below re-arms them.
            m_r_en    <= 1'b0;
            m_w_en    <= 1'b0;
            m_address <= 16'h0000;
            done_flag <= 1'b0;
            if (status_rd) done_reg <= 1'b0;
            if (busy && abort_wr) abort_pending_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (w_en && hit) begin
                        case (offset)
                            OFF_SRC_L: src_reg[7:0]  <= din;
                            OFF_SRC_H: src_reg[15:8] <= din;
                            OFF_DST_L: dst_reg[7:0]  <= din;
                            OFF_DST_H: dst_reg[15:8] <= din;
                            OFF_LEN:   len_reg       <= din;
                            default:   ;
                        endcase
                    end
                    if (start_wr && !abort_wr && (len_reg != 8'h00)) begin
                        state_reg         <= REQ;
                        bus_req           <= 1'b1;
                        done_reg          <= 1'b0;
                        aborted_reg       <= 1'b0;
                        abort_pending_reg <= 1'b0;
`ifdef DMA_FILL_EN
                        fill_reg <= din[2];
                        if (din[2]) data_reg <= src_reg[7:0];
`endif
                    end
                end
                REQ: begin
                    if (abort_pending_reg || abort_wr) begin
                        state_reg         <= IDLE;
                        bus_req           <= 1'b0;
                        aborted_reg       <= 1'b1;
                        abort_pending_reg <= 1'b0;
                    end else if (bus_gnt) begin
                        if (fill_mode) begin
                            state_reg <= WRITE;
                            m_address <= dst_reg;
                            m_w_en    <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            m_address <= src_reg;
                            m_r_en    <= 1'b1;
                        end
                    end
                end
                READ: state_reg <= CAPTURE;
                CAPTURE: begin
                    data_reg  <= m_din;
                    state_reg <= WRITE;
                    m_address <= dst_reg;
                    m_w_en    <= 1'b1;
                end
                WRITE: begin
                    len_reg <= len_reg - 8'd1;
                    dst_reg <= dst_reg + 16'd1;
                    if (!fill_mode) src_reg <= src_reg + 16'd1;
                    // The final byte completes the transfer even if an abort is pending.
                    if (len_reg == 8'd1) begin
                        state_reg         <= IDLE;
                        bus_req           <= 1'b0;
                        done_reg          <= 1'b1;
                        done_flag         <= 1'b1;
                        abort_pending_reg <= 1'b0;
                    end else if (abort_pending_reg || abort_wr) begin
                        state_reg         <= IDLE;
                        bus_req           <= 1'b0;
                        aborted_reg       <= 1'b1;
                        abort_pending_reg <= 1'b0;
                    end else if (bus_gnt) begin
                        if (fill_mode) begin
                            state_reg <= WRITE;
                            m_address <= dst_reg + 16'd1;
                            m_w_en    <= 1'b1;
                        end else begin
                            state_reg <= READ;
                            m_address <= src_reg + 16'd1;
                            m_r_en    <= 1'b1;
                        end
                    end else begin
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_controller.sv
// Scoreboard bench for dma_controller: stimulus queues expected bus/register events, a negedge monitor checks them.
module tb_dma_controller;

    localparam logic [7:0] BASE = 8'h20;
    localparam int EV_RD   = 0;
    localparam int EV_WR   = 1;
    localparam int EV_DONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  address = 8'h00;
    logic        w_en = 1'b0;
    logic        r_en = 1'b0;
    logic [7:0]  dout;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] m_address;
    logic [7:0]  m_dout;
    logic        m_w_en;
    logic        m_r_en;
    logic [7:0]  m_din = 8'h00;
    logic        done_flag;

    logic [7:0]  mem [0:65535];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [7:0]  data;
        int          cyc;
    } ev_t;
    typedef struct {
        string      name;
        logic [7:0] val;
    } rd_t;
    ev_t bus_q[$];
    rd_t reg_q[$];

    dma_controller #(.DMA_ADDRESS(BASE)) dut (
        .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
        .dout(dout), .bus_req(bus_req), .bus_gnt(bus_gnt), .m_address(m_address),
        .m_dout(m_dout), .m_w_en(m_w_en), .m_r_en(m_r_en), .m_din(m_din), .done_flag(done_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple memory slave: read data appears the cycle after m_r_en.
    always @(posedge clk) begin
        if (m_r_en) m_din <= mem[m_address];
        if (m_w_en) mem[m_address] <= m_dout;
    end

    function automatic void push_ev(input int kind, input logic [15:0] a, input logic [7:0] d, input int c);
        ev_t e;
        e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
        bus_q.push_back(e);
    endfunction

    task automatic check_ev(input int kind, input logic [15:0] a, input logic [7:0] d);
        ev_t e;
        n_vec++;
        if (bus_q.size() == 0) begin
            n_err++;
            $display("FAIL bus_unexpected: got kind=%0d addr=%h data=%h cyc=%0d, required no event", kind, a, d, cyc);
        end else begin
            e = bus_q.pop_front();
            if (e.kind != kind || e.addr != a || e.data != d || (e.cyc >= 0 && e.cyc != cyc)) begin
                n_err++;
                $display("FAIL bus_event: got kind=%0d addr=%h data=%h cyc=%0d, required kind=%0d addr=%h data=%h cyc=%0d",
                         kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
            end else begin
                $display("txn kind=%0d addr=%h data=%h cyc=%0d ok", kind, a, d, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        rd_t r;
        if (rst) begin
            if (m_r_en && m_w_en) begin
                n_err++;
                $display("FAIL rw_overlap: got m_r_en=1 m_w_en=1, required not both");
            end
            if (!m_r_en && !m_w_en && (m_address != 16'h0000 || m_dout != 8'h00)) begin
                n_err++;
                $display("FAIL idle_bus: got addr=%h dout=%h, required 0000/00", m_address, m_dout);
            end
            if (m_r_en) check_ev(EV_RD, m_address, 8'h00);
            if (m_w_en) check_ev(EV_WR, m_address, m_dout);
            if (done_flag) check_ev(EV_DONE, 16'h0000, 8'h00);
            if (r_en) begin
                n_vec++;
                if (reg_q.size() == 0) begin
                    n_err++;
                    $display("FAIL reg_unexpected: got %h, required no read", dout);
                end else begin
                    r = reg_q.pop_front();
                    if (dout !== r.val) begin
                        n_err++;
                        $display("FAIL %s: got %h, required %h", r.name, dout, r.val);
                    end else begin
                        $display("txn read %s = %h ok", r.name, dout);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] off, input logic [7:0] v);
        @(posedge clk); #1;
        address = BASE + {5'd0, off}; din = v; w_en = 1'b1;
        @(posedge clk); #1;
        w_en = 1'b0; address = 8'h00; din = 8'h00;
    endtask

    task automatic rd(input string nm, input logic [2:0] off, input logic [7:0] exp);
        rd_t r;
        r.name = nm; r.val = exp;
        reg_q.push_back(r);
        @(posedge clk); #1;
        address = BASE + {5'd0, off}; r_en = 1'b1;
        @(posedge clk); #1;
        r_en = 1'b0; address = 8'h00;
    endtask

    task automatic setup(input logic [15:0] src, input logic [15:0] dst, input logic [7:0] len);
        wr(3'd0, src[7:0]); wr(3'd1, src[15:8]);
        wr(3'd2, dst[7:0]); wr(3'd3, dst[15:8]);
        wr(3'd4, len);
    endtask

    task automatic start(input logic [7:0] ctrl, output int s);
        wr(3'd5, ctrl);
        s = cyc;
    endtask

    task automatic drain(input string nm, input int budget);
        int k;
        k = 0;
        while (bus_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        repeat (4) @(posedge clk);
        n_vec++;
        if (bus_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d pending bus events after %0d cycles, required 0", nm, bus_q.size(), budget);
            bus_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int g;
        logic [7:0] copy_dat [4];
        copy_dat = '{8'h3C, 8'hA7, 8'h00, 8'hFF};
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) mem[16'h0100 + i] = copy_dat[i];
        mem[16'h0400] = 8'h11; mem[16'h0401] = 8'h22; mem[16'h0402] = 8'h33;
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'h96;
        mem[16'h0600] = 8'hE1; mem[16'h0601] = 8'hE2;

        // Reset state
        #12;
        chk("rst_bus_req", {15'd0, bus_req}, 16'h0000);
        chk("rst_m_w_en", {15'd0, m_w_en}, 16'h0000);
        chk("rst_m_address", m_address, 16'h0000);
        chk("rst_done_flag", {15'd0, done_flag}, 16'h0000);
        @(posedge clk); #1; rst = 1'b1;
        rd("rst_src_l", 3'd0, 8'h00); rd("rst_src_h", 3'd1, 8'h00);
        rd("rst_dst_l", 3'd2, 8'h00); rd("rst_dst_h", 3'd3, 8'h00);
        rd("rst_len", 3'd4, 8'h00);   rd("rst_status", 3'd5, 8'h00);

        // Four-byte copy with continuous grant
        bus_gnt = 1'b1;
        setup(16'h0100, 16'h0200, 8'd4);
        start(8'h01, s);
        g = s + 1;
        for (int i = 0; i < 4; i++) begin
            push_ev(EV_RD, 16'h0100 + 16'(i), 8'h00, g + 3 * i);
            push_ev(EV_WR, 16'h0200 + 16'(i), copy_dat[i], g + 3 * i + 2);
        end
        push_ev(EV_DONE, 16'h0000, 8'h00, g + 12);
        drain("copy_drain", 40);
        rd("copy_status", 3'd5, 8'h02);
        rd("copy_status_clr", 3'd5, 8'h00);
        rd("copy_src_l", 3'd0, 8'h04); rd("copy_src_h", 3'd1, 8'h01);
        rd("copy_dst_l", 3'd2, 8'h04); rd("copy_len", 3'd4, 8'h00);

        // Grant dropped for 5 cycles after the first write
        setup(16'h0400, 16'h0500, 8'd3);
        start(8'h01, s);
        g = s + 1;
        push_ev(EV_RD, 16'h0400, 8'h00, g);
        push_ev(EV_WR, 16'h0500, 8'h11, g + 2);
        push_ev(EV_RD, 16'h0401, 8'h00, g + 8);
        push_ev(EV_WR, 16'h0501, 8'h22, g + 10);
        push_ev(EV_RD, 16'h0402, 8'h00, g + 11);
        push_ev(EV_WR, 16'h0502, 8'h33, g + 13);
        push_ev(EV_DONE, 16'h0000, 8'h00, g + 14);
        repeat (3) @(posedge clk);
        #1 bus_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_bus_req", {15'd0, bus_req}, 16'h0001);
            chk("stall_no_strobe", {14'd0, m_r_en, m_w_en}, 16'h0000);
        end
        bus_gnt = 1'b1;
        drain("stall_drain", 40);
        rd("stall_status", 3'd5, 8'h02);

        // Pointer wrap at 0xFFFF
        setup(16'hFFFF, 16'h07FE, 8'd3);
        start(8'h01, s);
        g = s + 1;
        push_ev(EV_RD, 16'hFFFF, 8'h00, g);
        push_ev(EV_WR, 16'h07FE, 8'h5A, g + 2);
        push_ev(EV_RD, 16'h0000, 8'h00, g + 3);
        push_ev(EV_WR, 16'h07FF, 8'hC3, g + 5);
        push_ev(EV_RD, 16'h0001, 8'h00, g + 6);
        push_ev(EV_WR, 16'h0800, 8'h96, g + 8);
        push_ev(EV_DONE, 16'h0000, 8'h00, g + 9);
        drain("wrap_drain", 40);
        rd("wrap_src_l", 3'd0, 8'h02); rd("wrap_src_h", 3'd1, 8'h00);
        rd("wrap_dst_l", 3'd2, 8'h01); rd("wrap_dst_h", 3'd3, 8'h08);
        rd("wrap_status", 3'd5, 8'h02);

        // Abort during the second byte's READ
        setup(16'h0600, 16'h0700, 8'd10);
        start(8'h01, s);
        g = s + 1;
        push_ev(EV_RD, 16'h0600, 8'h00, g);
        push_ev(EV_WR, 16'h0700, 8'hE1, g + 2);
        push_ev(EV_RD, 16'h0601, 8'h00, g + 3);
        push_ev(EV_WR, 16'h0701, 8'hE2, g + 5);
        repeat (3) @(posedge clk);
        #1;
        wr(3'd5, 8'h02);
        drain("abort_drain", 20);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("abort_bus_req", {15'd0, bus_req}, 16'h0000);
        rd("abort_status", 3'd5, 8'h04);
        rd("abort_len", 3'd4, 8'h08);
        rd("abort_src_l", 3'd0, 8'h02);
        rd("abort_dst_l", 3'd2, 8'h02);
        wr(3'd5, 8'h02);
        rd("idle_abort_status", 3'd5, 8'h04);
        start(8'h03, s);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("start_abort_bus_req", {15'd0, bus_req}, 16'h0000);
        end
        rd("start_abort_status", 3'd5, 8'h04);

        // Reset asserted during a WRITE
        setup(16'h0100, 16'h0900, 8'd2);
        start(8'h01, s);
        g = s + 1;
        push_ev(EV_RD, 16'h0100, 8'h00, g);
        push_ev(EV_WR, 16'h0900, 8'h3C, g + 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("pre_rst_m_w_en", {15'd0, m_w_en}, 16'h0001);
        rst = 1'b0;
        #1;
        chk("mid_rst_m_w_en", {15'd0, m_w_en}, 16'h0000);
        chk("mid_rst_bus_req", {15'd0, bus_req}, 16'h0000);
        chk("mid_rst_m_address", m_address, 16'h0000);
        chk("mid_rst_m_dout", {8'd0, m_dout}, 16'h0000);
        @(posedge clk); #1; rst = 1'b1;
        drain("rst_drain", 10);
        rd("post_rst_src_l", 3'd0, 8'h00); rd("post_rst_src_h", 3'd1, 8'h00);
        rd("post_rst_dst_l", 3'd2, 8'h00); rd("post_rst_dst_h", 3'd3, 8'h00);
        rd("post_rst_len", 3'd4, 8'h00);   rd("post_rst_status", 3'd5, 8'h00);

        // Start with LEN == 0 is ignored
        start(8'h01, s);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("len0_bus_req", {15'd0, bus_req}, 16'h0000);
        end
        rd("len0_status", 3'd5, 8'h00);

`ifdef DMA_FILL_EN
        // Fill mode: constant SRC_L byte, no reads, one cycle per byte
        setup(16'h00A5, 16'h0300, 8'd3);
        start(8'h05, s);
        g = s + 1;
        push_ev(EV_WR, 16'h0300, 8'hA5, g);
        push_ev(EV_WR, 16'h0301, 8'hA5, g + 1);
        push_ev(EV_WR, 16'h0302, 8'hA5, g + 2);
        push_ev(EV_DONE, 16'h0000, 8'h00, g + 3);
        drain("fill_drain", 20);
        rd("fill_status", 3'd5, 8'h0A);
        rd("fill_src_l", 3'd0, 8'hA5);
        rd("fill_dst_l", 3'd2, 8'h03);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
